ascon_state_loader: RTL and testbench
=====================================

Name: ascon_state_loader

Overview:
- Parametrised successor of the fixed-width ASCON state assembler.
- Builds the 320-bit type_state S (IV || K || N) from a narrow word stream using a valid/ready handshake, instead of from wide parallel IV/key/nonce buses.
- Key length and bus width are selectable, so one block serves Ascon-128 and Ascon-80pq.
- Sits between the host/key-load interface and the permutation datapath, and hands the completed state over with a second valid/ready handshake.

Parameters:
- WORD_W, 32, input bus width in bits; legal values 8, 16, 32, 64 (must divide 64).
- KEY_W, 128, key length in bits; legal values 128, 160.
- IV_W, 320-128-KEY_W, derived, not overridable: 64 for KEY_W=128, 32 for KEY_W=160.
- BEATS, 320/WORD_W, derived: beats per full state load.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- load_start_i  in  1  starts a new state load.
- data_i  in  WORD_W  stream word; first beat is most significant.
- data_valid_i  in  1  data_i is valid.
- data_ready_o  out  1  loader accepts a beat this cycle.
- state_o  out  320  assembled state (type_state); state_o[0] is S0.
- state_valid_o  out  1  state_o is complete.
- state_ready_i  in  1  consumer takes state_o.
- busy_o  out  1  high in LOAD or HOLD.

Behaviour:
- Reset (rst_i=1 at clock edge), wins over every other input: FSM→IDLE; state register=0; beat counter=0; data_ready_o=0, state_valid_o=0, busy_o=0.
- Reset mid-load or mid-hold discards everything with no handoff.

FSM states IDLE, LOAD, HOLD:
- IDLE:
  - load_start_i=1 → LOAD next cycle.
  - At that edge, state register cleared to 0 and beat counter=0.
- LOAD:
  - data_ready_o=1, decoded from the state register, not combinationally from inputs.
  - A beat is accepted when data_valid_i & data_ready_o.
  - Beat k (0..BEATS-1) writes bits [319-k*WORD_W -: WORD_W] of the flattened state, S0 MSB = bit 319.
  - Counter increments per accepted beat.
  - Accepting beat BEATS-1 → HOLD next cycle.
  - data_valid_i low stalls indefinitely with no timeout.
  - load_start_i=1 in LOAD aborts: register cleared, counter=0, stay in LOAD. Any beat presented in the same cycle is dropped.
- HOLD:
  - state_valid_o=1, data_ready_o=0.
  - state_o stable until handshake.
  - state_ready_i=1 → IDLE next cycle; state_valid_o low.
  - state_ready_i=1 and load_start_i=1 in the same cycle → handoff completes and FSM goes directly to LOAD, register cleared (back-to-back loads).
  - load_start_i alone in HOLD is ignored.

Timing and field rules:
- Latency: state_valid_o rises the cycle after the last beat is accepted. Minimum load time is BEATS+1 cycles from load_start_i.
- state_o keeps its value in IDLE after handoff; it is cleared only on the next start.
- Field map: IV occupies bits [319 -: IV_W], key [255+KEY_W-128 -: KEY_W]... concretely the key occupies bits [319-IV_W -: KEY_W], nonce bits [127:0].
- The loader does not interpret field contents; field boundaries are informational only.
- busy_o = (FSM != IDLE).

Optional Feature:
- Macro: ASCON_LOADER_XOR_EN.
- Defined:
  - Extra input port xor_mode_i (1 bit), sampled with load_start_i and held for the whole load.
  - If xor_mode_i=1, the register is NOT cleared on start. Each accepted beat XORs into the addressed slice instead of overwriting it.
  - This supports key/data absorption into an existing state.
  - An abort during an XOR load restores nothing: the partially XORed contents remain.
- Not defined:
  - Port absent.
  - Every load clears and overwrites.

Test Plan:
- WORD_W=64, KEY_W=128; start, then beats 0x80400c0600000000, 0x0001020304050607, 0x08090a0b0c0d0e0f, 0x0011223344556677, 0x8899aabbccddeeff → state_valid_o high 1 cycle after beat 4. S0..S4 equal the beats in order. busy_o high from start+1.
- WORD_W=32, KEY_W=160; 10 beats with data_valid_i deasserted every other cycle → exactly 10 beats captured. state_valid_o never high before beat 10. S0 = {beat0, beat1}.
- Abort: after 3 of 5 beats, pulse load_start_i while presenting 0xDEAD... → that beat is dropped. Next 5 beats form S, with no trace of the first 3.
- Backpressure and back-to-back: hold state_ready_i=0 for 4 cycles → state_o stable and data_ready_o=0. Then state_ready_i=1 with load_start_i=1 → next cycle LOAD, state_valid_o=0, register=0.
- Reset: rst_i=1 during LOAD and during HOLD → next cycle all outputs 0 and FSM in IDLE. Reset asserted together with load_start_i → reset wins.
- With ASCON_LOADER_XOR_EN: load all-0x5555… beats, hand off, then start with xor_mode_i=1 and load all-0xFFFF… beats → state_o = all-0xAAAA….

Source files
------------

// File: rtl/ascon_state_loader.sv
// ascon_state_loader: assembles the 320-bit Ascon state S = IV || K || N from a narrow
// word stream and hands the completed state over with a valid/ready handshake.
// Ports:
//   clk_i, rst_i                          clock (rising edge), synchronous active-high reset
//   load_start_i                          start a new load (restarts a load in progress)
//   data_i, data_valid_i, data_ready_o    WORD_W beat stream, first beat most significant
//   state_o, state_valid_o, state_ready_i state handoff; state_o[0] is S0
//   busy_o                                high while loading or holding a state
// Optional: define ASCON_LOADER_XOR_EN to add xor_mode_i; an XOR load keeps the existing
// state and XORs every accepted beat into its slice instead of overwriting it.
module ascon_state_loader #(
    parameter int WORD_W = 32,
    parameter int KEY_W  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
`ifdef ASCON_LOADER_XOR_EN
    input  logic              xor_mode_i,
`endif
    input  logic [WORD_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic [0:4][63:0]  state_o,
    output logic              state_valid_o,
    input  logic              state_ready_i,
    output logic              busy_o
);
    localparam int IV_W  = 320 - 128 - KEY_W;
    localparam int BEATS = 320 / WORD_W;
    localparam int CW    = $clog2(BEATS);

    if ((IV_W != 64 && IV_W != 32) || (64 % WORD_W) != 0 || WORD_W < 8) begin : g_bad_params
        $error("ascon_state_loader: unsupported WORD_W/KEY_W combination");
    end

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} fsm_t;

    fsm_t           fsm, fsm_n;
    logic [319:0]   st, st_n, ins, msk;
    logic [CW-1:0]  cnt, cnt_n;
    logic           go, xm, xs;

`ifdef ASCON_LOADER_XOR_EN
    // The mode is captured with the start and governs every beat of that load.
    always_ff @(posedge clk_i) begin
        if (rst_i) xm <= 1'b0;
        else if (go) xm <= xor_mode_i;
    end
    assign xs = xor_mode_i;
`else
    assign xm = 1'b0;
    assign xs = 1'b0;
`endif

    always_comb begin
        fsm_n = fsm;
        st_n  = st;
        cnt_n = cnt;
        // Beat k lands at flattened bits [319-k*WORD_W -: WORD_W].
        ins   = {data_i, {(320-WORD_W){1'b0}}} >> (32'(cnt) * WORD_W);
        msk   = {{WORD_W{1'b1}}, {(320-WORD_W){1'b0}}} >> (32'(cnt) * WORD_W);
        // A start is honoured in IDLE and LOAD, and in HOLD only together with the handoff.
        go    = load_start_i && (fsm != HOLD || state_ready_i);
        if (go) begin
            fsm_n = LOAD;
            cnt_n = '0;
            st_n  = xs ? st : '0;
        end else if (fsm == LOAD && data_valid_i) begin
            st_n  = xm ? st ^ ins : (st & ~msk) | ins;
            cnt_n = cnt + 1'b1;
            fsm_n = (cnt == CW'(BEATS-1)) ? HOLD : LOAD;
        end else if (fsm == HOLD && state_ready_i) begin
            fsm_n = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm <= IDLE;
            st  <= '0;
            cnt <= '0;
        end else begin
            fsm <= fsm_n;
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    assign data_ready_o  = (fsm == LOAD);
    assign state_valid_o = (fsm == HOLD);
    assign busy_o        = (fsm != IDLE);
    assign state_o       = st;
endmodule

// File: tb/tb_ascon_state_loader.sv
// tb_ascon_state_loader: scoreboard bench for ascon_state_loader (WORD_W=32, KEY_W=160).
module tb_ascon_state_loader;
    localparam int W = 32;
    localparam int K = 160;
    localparam int B = 320 / W;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0, dv = 1'b0, sr = 1'b0;
    logic [W-1:0]    data = '0;
    logic            dr, sv, busy;
    logic [0:4][63:0] st;
`ifdef ASCON_LOADER_XOR_EN
    logic            xm = 1'b0;
`endif

    always #5 clk = ~clk;

    ascon_state_loader #(.WORD_W(W), .KEY_W(K)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .load_start_i(start),
`ifdef ASCON_LOADER_XOR_EN
        .xor_mode_i(xm),
`endif
        .data_i(data),
        .data_valid_i(dv),
        .data_ready_o(dr),
        .state_o(st),
        .state_valid_o(sv),
        .state_ready_i(sr),
        .busy_o(busy)
    );

    int checks = 0, errors = 0;
    logic [319:0] expq[$];
    logic [319:0] acc, held;
    logic hv = 1'b0;

    task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: state must stay frozen while held, and every handoff pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            hv <= 1'b0;
        end else begin
            if (sv && hv) chk("hold_stable", st, held);
            if (sv && sr) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handoff: got %h with no expected state queued", st);
                end else begin
                    chk("handoff_state", st, expq.pop_front());
                end
            end
            hv   <= sv && !sr;
            held <= st;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The model: S is simply the accepted beats since the last start, concatenated MSB first.
    task automatic start_load(input logic x);
`ifdef ASCON_LOADER_XOR_EN
        xm = x;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = '0;
        chk("busy_after_start", busy, 1);
        chk("ready_in_load", dr, 1);
        if (!x) chk("clear_on_start", st, 0);
    endtask

    task automatic send(input logic [W-1:0] w, input int stall);
        int n = 0;
        dv = 1'b0;
        repeat (stall) tick();
        chk("no_early_valid", sv, 0);
        dv = 1'b1;
        data = w;
        while (!dr && n < 50) begin
            tick();
            n++;
        end
        if (!dr) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got data_ready_o=0 required 1 within 50 cycles");
        end
        tick();
        dv = 1'b0;
        acc = (acc << W) | 320'(w);
    endtask

    task automatic take(input int delay);
        int n = 0;
        while (!sv && n < 100) begin
            tick();
            n++;
        end
        if (!sv) begin
            checks++;
            errors++;
            $display("FAIL state_valid_wait: got state_valid_o=0 required 1 within 100 cycles");
        end
        repeat (delay) tick();
        sr = 1'b1;
        tick();
        sr = 1'b0;
        chk("idle_after_take", {sv, busy}, 0);
    endtask

    logic [63:0] vec [5] = '{64'h80400c0600000000, 64'h0001020304050607,
                             64'h08090a0b0c0d0e0f, 64'h0011223344556677, 64'h8899aabbccddeeff};

    initial begin
        // Reset held together with a start request: reset must win.
        start = 1'b1;
        tick();
        tick();
        chk("reset_outputs", {dr, sv, busy}, 0);
        chk("reset_state", st, 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_reset", {dr, sv, busy}, 0);

        // Known vector, no stalls: valid the cycle after the last beat.
        start_load(1'b0);
        for (int i = 0; i < 5; i++) begin
            send(vec[i][63:32], 0);
            send(vec[i][31:0], 0);
        end
        chk("valid_latency", sv, 1);
        chk("ready_low_in_hold", dr, 0);
        expq.push_back(acc);
        take(0);
        chk("s0_kept_in_idle", st[0], vec[0]);
        chk("s4_kept_in_idle", st[4], vec[4]);

        // data_valid_i low every other cycle.
        start_load(1'b0);
        for (int i = 0; i < B; i++) send($urandom, 1);
        chk("valid_after_stalled_load", sv, 1);
        expq.push_back(acc);
        take(1);

        // Abort after 3 beats, with a beat presented on the abort cycle.
        start_load(1'b0);
        for (int i = 0; i < 3; i++) send($urandom, 0);
        start = 1'b1;
        dv = 1'b1;
        data = 32'hdeadbeef;
        tick();
        start = 1'b0;
        dv = 1'b0;
        acc = '0;
        chk("abort_clears", st, 0);
        chk("abort_stays_load", {dr, busy}, 2'b11);
        for (int i = 0; i < B; i++) send($urandom, $urandom_range(0, 1));
        expq.push_back(acc);
        take(0);

        // Backpressure, a lone start in HOLD, then a back-to-back handoff.
        start_load(1'b0);
        for (int i = 0; i < B; i++) send($urandom, 0);
        expq.push_back(acc);
        for (int i = 0; i < 4; i++) begin
            start = (i == 2);
            tick();
            chk("hold_valid", {sv, dr}, 2'b10);
        end
        start = 1'b1;
        sr = 1'b1;
        tick();
        start = 1'b0;
        sr = 1'b0;
        acc = '0;
        chk("b2b_outputs", {sv, dr, busy}, 3'b011);
        chk("b2b_cleared", st, 0);
        for (int i = 0; i < B; i++) send($urandom, 0);
        expq.push_back(acc);
        take(2);

        // Randomised loads.
        for (int t = 0; t < 12; t++) begin
            start_load(1'b0);
            for (int i = 0; i < B; i++) send($urandom, $urandom_range(0, 2));
            expq.push_back(acc);
            take($urandom_range(0, 3));
        end

        // Reset during LOAD.
        start_load(1'b0);
        send($urandom, 0);
        send($urandom, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_load_outputs", {dr, sv, busy}, 0);
        chk("rst_load_state", st, 0);

        // Reset during HOLD: no handoff happens.
        start_load(1'b0);
        for (int i = 0; i < B; i++) send($urandom, 0);
        chk("hold_reached", sv, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_outputs", {dr, sv, busy}, 0);
        chk("rst_hold_state", st, 0);

`ifdef ASCON_LOADER_XOR_EN
        start_load(1'b0);
        for (int i = 0; i < B; i++) send({(W/8){8'h55}}, 0);
        expq.push_back(acc);
        take(0);
        start_load(1'b1);
        chk("xor_start_keeps", st, {40{8'h55}});
        for (int i = 0; i < B; i++) send({(W/8){8'hff}}, 0);
        expq.push_back({40{8'haa}});
        take(0);
        xm = 1'b0;
`endif

        // One more plain load after the resets.
        start_load(1'b0);
        for (int i = 0; i < B; i++) send($urandom, 0);
        expq.push_back(acc);
        take(0);

        repeat (2) tick();
        chk("queue_drained", 320'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
